// File: rtl/counter_snapshot_reader.sv
// Builds a torn-free 64-bit snapshot from the event counter's 32-bit port.
// It reads the low word atomically, then reads the latched high word, and returns the value and delta on a valid/ready port.
module counter_snapshot_reader #(
    parameter int unsigned ACK_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        snap_i,
    output logic        req_o,
    output logic        atomic_o,
    input  logic        ack_i,
    input  logic [31:0] count_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [63:0] value_o,
    output logic [63:0] delta_o,
    output logic        busy_o,
    output logic        timeout_o
);

    typedef enum logic [2:0] {
        IDLE,
        LO_REQ,
        LO_WAIT,
        HI_REQ,
        HI_WAIT,
        OUT
    } state_t;

    localparam logic [7:0] TIMER_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      state_reg;
    logic [31:0] lo_reg;
    logic [63:0] prev_reg;
    logic        pending_reg;
    logic [7:0]  timer_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            req_o       <= 1'b0;
            atomic_o    <= 1'b0;
            valid_o     <= 1'b0;
            busy_o      <= 1'b0;
            timeout_o   <= 1'b0;
            value_o     <= '0;
            delta_o     <= '0;
            lo_reg      <= '0;
            prev_reg    <= '0;
            pending_reg <= 1'b0;
            timer_reg   <= '0;
        end else begin
            req_o     <= 1'b0;
            atomic_o  <= 1'b0;
            timeout_o <= 1'b0;

            // Requests that arrive mid-snapshot collapse into one queued snapshot.
            if (snap_i && (state_reg != IDLE)) begin
                pending_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (snap_i || pending_reg) begin
                        pending_reg <= 1'b0;
                        state_reg   <= LO_REQ;
                        req_o       <= 1'b1;
                        atomic_o    <= 1'b1;
                        busy_o      <= 1'b1;
                    end
                end
                LO_REQ: begin
                    timer_reg <= '0;
                    state_reg <= LO_WAIT;
                end
                LO_WAIT: begin
                    // If the ack arrives on the expiry cycle, the ack wins over the timeout.
                    if (ack_i) begin
                        lo_reg    <= count_i;
                        state_reg <= HI_REQ;
                        req_o     <= 1'b1;
                    end else if (timer_reg == TIMER_LAST) begin
                        timeout_o <= 1'b1;
                        busy_o    <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        timer_reg <= timer_reg + 8'd1;
                    end
                end
                HI_REQ: begin
                    timer_reg <= '0;
                    state_reg <= HI_WAIT;
                end
                HI_WAIT: begin
                    if (ack_i) begin
                        value_o   <= {count_i, lo_reg};
                        delta_o   <= {count_i, lo_reg} - prev_reg;
                        valid_o   <= 1'b1;
                        state_reg <= OUT;
                    end else if (timer_reg == TIMER_LAST) begin
                        timeout_o <= 1'b1;
                        busy_o    <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        timer_reg <= timer_reg + 8'd1;
                    end
                end
                OUT: begin
                    if (ready_i) begin
                        prev_reg  <= value_o;
                        valid_o   <= 1'b0;
                        busy_o    <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    busy_o    <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_snapshot_reader.sv
// Directed bench for counter_snapshot_reader.
// A behavioural 64-bit counter gives a 1-cycle ack and latches the high word on each atomic read.
module tb_counter_snapshot_reader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        snap_i = 1'b0;
    logic        req_o;
    logic        atomic_o;
    logic        ack_i = 1'b0;
    logic [31:0] count_i = '0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [63:0] value_o;
    logic [63:0] delta_o;
    logic        busy_o;
    logic        timeout_o;

    logic [63:0] cnt = '0;
    logic [63:0] cnt_load_val = '0;
    logic        cnt_load = 1'b0;
    logic        cnt_inc = 1'b0;
    logic        no_ack_lo = 1'b0;
    logic        no_ack_hi = 1'b0;
    logic [31:0] latch_hi = '0;

    int n_cmp = 0;
    int n_bad = 0;

    counter_snapshot_reader #(.ACK_TIMEOUT(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .snap_i    (snap_i),
        .req_o     (req_o),
        .atomic_o  (atomic_o),
        .ack_i     (ack_i),
        .count_i   (count_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .value_o   (value_o),
        .delta_o   (delta_o),
        .busy_o    (busy_o),
        .timeout_o (timeout_o)
    );

    always #5 clk = ~clk;

    // Counter model: a read returns the count seen on the request edge, before this edge's increment.
    always @(posedge clk) begin
        ack_i <= 1'b0;
        if (req_o) begin
            if (atomic_o) begin
                count_i  <= cnt[31:0];
                latch_hi <= cnt[63:32];
                ack_i    <= !no_ack_lo;
            end else begin
                count_i <= latch_hi;
                ack_i   <= !no_ack_hi;
            end
        end
        if (cnt_load) cnt <= cnt_load_val;
        else if (cnt_inc) cnt <= cnt + 64'd1;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    task automatic load_cnt(input logic [63:0] val, input logic inc);
        cnt_load     = 1'b1;
        cnt_load_val = val;
        cnt_inc      = inc;
        @(negedge clk);
        cnt_load = 1'b0;
    endtask

    task automatic pulse_snap();
        snap_i = 1'b1;
        @(negedge clk);
        snap_i = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!valid_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, {63'd0, valid_o}, 64'd1);
    endtask

    task automatic accept();
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
    endtask

    initial begin
        int t;
        int reqs;
        logic saw_valid;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_val("rst_req", {63'd0, req_o}, 64'd0);
        check_val("rst_valid", {63'd0, valid_o}, 64'd0);
        check_val("rst_busy", {63'd0, busy_o}, 64'd0);
        check_val("rst_value", value_o, 64'd0);
        check_val("rst_delta", delta_o, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Basic latency check and first snapshot delta (prev is 0)
        load_cnt(64'h0000_0001_0000_0005, 1'b0);
        pulse_snap();
        check_val("t1_req_lo", {62'd0, req_o, atomic_o}, 64'd3);
        check_val("t1_busy", {63'd0, busy_o}, 64'd1);
        @(negedge clk);
        check_val("t1_gap1", {62'd0, req_o, atomic_o}, 64'd0);
        check_val("t1_ack_lo", {63'd0, ack_i}, 64'd1);
        @(negedge clk);
        check_val("t1_req_hi", {62'd0, req_o, atomic_o}, 64'd2);
        @(negedge clk);
        check_val("t1_gap2", {61'd0, req_o, atomic_o, valid_o}, 64'd0);
        @(negedge clk);
        check_val("t1_valid", {63'd0, valid_o}, 64'd1);
        check_val("t1_value", value_o, 64'h0000_0001_0000_0005);
        check_val("t1_delta", delta_o, 64'h0000_0001_0000_0005);
        accept();

        // Running counter crosses the 32-bit carry: hi must come from the latch
        load_cnt(64'h0000_0000_FFFF_FFFD, 1'b1);
        pulse_snap();
        wait_valid("t2_valid_a");
        check_val("t2_value_a", value_o, 64'h0000_0000_FFFF_FFFE);
        check_val("t2_delta_a", delta_o, 64'hFFFF_FFFF_FFFF_FFF9);
        snap_i  = 1'b1;
        ready_i = 1'b1;
        @(negedge clk);
        snap_i  = 1'b0;
        ready_i = 1'b0;
        wait_valid("t2_valid_b");
        check_val("t2_value_b", value_o, 64'h0000_0001_0000_0004);
        check_val("t2_delta_b", delta_o, 64'd6);
        cnt_inc = 1'b0;
        accept();

        // Backpressure: outputs hold, two snap pulses coalesce into one
        load_cnt(64'h0000_0002_0000_0000, 1'b0);
        pulse_snap();
        wait_valid("t3_valid_a");
        check_val("t3_delta_a", delta_o, 64'h0000_0000_FFFF_FFFC);
        for (int i = 0; i < 10; i++) begin
            if (i == 2 || i == 6) snap_i = 1'b1;
            @(negedge clk);
            snap_i = 1'b0;
            check_val($sformatf("t3_hold_valid_%0d", i), {63'd0, valid_o}, 64'd1);
            check_val($sformatf("t3_hold_value_%0d", i), value_o, 64'h0000_0002_0000_0000);
            check_val($sformatf("t3_hold_delta_%0d", i), delta_o, 64'h0000_0000_FFFF_FFFC);
        end
        accept();
        wait_valid("t3_valid_b");
        check_val("t3_value_b", value_o, 64'h0000_0002_0000_0000);
        check_val("t3_delta_b", delta_o, 64'd0);
        accept();
        reqs = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (req_o) reqs++;
        end
        check_val("t3_no_extra_req", 64'(reqs), 64'd0);

        // High-word ack suppressed: timeout, then delta is relative to the last accepted value
        no_ack_hi = 1'b1;
        load_cnt(64'h0000_0003_0000_0000, 1'b0);
        pulse_snap();
        t = 0;
        while (!(req_o && !atomic_o) && t < 20) begin
            @(negedge clk);
            t++;
        end
        check_val("t4_hi_req_seen", {62'd0, req_o, atomic_o}, 64'd2);
        t = 0;
        saw_valid = 1'b0;
        while (!timeout_o && t < 30) begin
            @(negedge clk);
            t++;
            if (valid_o) saw_valid = 1'b1;
        end
        // The HI_REQ cycle and 8 wait cycles come first, then the pulse follows.
        check_val("t4_timeout_dist", 64'(t), 64'd9);
        check_val("t4_no_valid", {63'd0, saw_valid}, 64'd0);
        @(negedge clk);
        check_val("t4_pulse_once", {63'd0, timeout_o}, 64'd0);
        check_val("t4_idle", {63'd0, busy_o}, 64'd0);
        no_ack_hi = 1'b0;
        pulse_snap();
        wait_valid("t4_valid");
        check_val("t4_value", value_o, 64'h0000_0003_0000_0000);
        check_val("t4_delta", delta_o, 64'h0000_0001_0000_0000);
        accept();

        // Modulo delta across 2^64 wrap
        load_cnt(64'hFFFF_FFFF_FFFF_FFF0, 1'b0);
        pulse_snap();
        wait_valid("t5_valid_a");
        check_val("t5_delta_a", delta_o, 64'hFFFF_FFFC_FFFF_FFF0);
        accept();
        load_cnt(64'h0000_0000_0000_0010, 1'b0);
        pulse_snap();
        wait_valid("t5_valid_b");
        check_val("t5_value_b", value_o, 64'h0000_0000_0000_0010);
        check_val("t5_delta_b", delta_o, 64'h0000_0000_0000_0020);
        accept();

        // Async reset in LO_WAIT with a pending request
        no_ack_lo = 1'b1;
        load_cnt(64'h0000_0005_0000_0007, 1'b0);
        pulse_snap();
        snap_i = 1'b1;
        @(negedge clk);
        snap_i = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check_val("t6_rst_ctrl", {59'd0, req_o, atomic_o, valid_o, busy_o, timeout_o}, 64'd0);
        check_val("t6_rst_value", value_o, 64'd0);
        check_val("t6_rst_delta", delta_o, 64'd0);
        @(negedge clk);
        no_ack_lo = 1'b0;
        reset_n = 1'b1;
        reqs = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req_o || busy_o) reqs++;
        end
        check_val("t6_quiet", 64'(reqs), 64'd0);
        pulse_snap();
        wait_valid("t6_valid");
        check_val("t6_value", value_o, 64'h0000_0005_0000_0007);
        check_val("t6_delta", delta_o, 64'h0000_0005_0000_0007);
        accept();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
